// File: rtl/gpio_pb_debounce_irq.sv
// rtl/gpio_pb_debounce_irq.sv - pushbutton sync, per-bit debounce, sticky edge capture and irq
module gpio_pb_debounce_irq #(
  parameter  int N_PB            = 5,
  parameter  int DEBOUNCE_CYCLES = 500000,
  localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic            clk,
  input  logic            clrn,
  input  logic [N_PB-1:0] pb_raw,
  input  logic [N_PB-1:0] int_en,
  input  logic [N_PB-1:0] edge_sel,
  input  logic            clr_valid,
  input  logic [N_PB-1:0] clr_mask,
  output logic [N_PB-1:0] pb_clean,
  output logic [N_PB-1:0] pending,
  output logic            irq
);

  localparam logic [CNT_W-1:0] TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_PB-1:0]  sync1;
  logic [N_PB-1:0]  sync2;
  logic [CNT_W-1:0] cnt [N_PB];
  logic [N_PB-1:0]  flip;
  logic [N_PB-1:0]  evt;
  logic [N_PB-1:0]  pending_nxt;

  // A flip happens on the edge where a mismatch has survived the full count.
  always_comb begin
    flip = '0;
    for (int i = 0; i < N_PB; i++) begin
      flip[i] = (sync2[i] != pb_clean[i]) && (cnt[i] == TERM);
    end
  end

  // New level equals 1 on a press; edge_sel=1 wants the release, so xor selects the match.
  assign evt         = flip & (sync2 ^ edge_sel) & int_en;
  assign pending_nxt = evt | (pending & ~({N_PB{clr_valid}} & clr_mask));

  always_ff @(posedge clk) begin
    if (!clrn) begin
      sync1    <= '0;
      sync2    <= '0;
      pb_clean <= '0;
      pending  <= '0;
      for (int i = 0; i < N_PB; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1   <= pb_raw;
      sync2   <= sync1;
      pending <= pending_nxt;
      for (int i = 0; i < N_PB; i++) begin
        if (sync2[i] == pb_clean[i]) begin
          cnt[i] <= '0;
        end else if (flip[i]) begin
          pb_clean[i] <= sync2[i];
          cnt[i]      <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign irq = |(pending & int_en);

endmodule

// File: tb/tb_gpio_pb_debounce_irq.sv
// tb/tb_gpio_pb_debounce_irq.sv - directed bench for gpio_pb_debounce_irq with DEBOUNCE_CYCLES=4
module tb_gpio_pb_debounce_irq;

  logic       clk;
  logic       clrn;
  logic [4:0] pb_raw;
  logic [4:0] int_en;
  logic [4:0] edge_sel;
  logic       clr_valid;
  logic [4:0] clr_mask;
  logic [4:0] pb_clean;
  logic [4:0] pending;
  logic       irq;

  int checks;
  int errors;

  gpio_pb_debounce_irq #(
    .N_PB(5),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk),
    .clrn(clrn),
    .pb_raw(pb_raw),
    .int_en(int_en),
    .edge_sel(edge_sel),
    .clr_valid(clr_valid),
    .clr_mask(clr_mask),
    .pb_clean(pb_clean),
    .pending(pending),
    .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    clrn      = 1'b0;
    pb_raw    = 5'h1F;
    int_en    = 5'h00;
    edge_sel  = 5'h00;
    clr_valid = 1'b0;
    clr_mask  = 5'h00;

    // reset with all buttons held
    step(3);
    chk("rst_clean", pb_clean, 5'h00);
    chk("rst_pending", pending, 5'h00);
    chk("rst_irq", {4'b0, irq}, 5'h00);
    clrn = 1'b1;
    step(5);
    chk("rel_clean_e5", pb_clean, 5'h00);
    step(1);
    chk("rel_clean_e6", pb_clean, 5'h1F);
    chk("rel_pending", pending, 5'h00);

    // back to an idle baseline
    clrn   = 1'b0;
    pb_raw = 5'h00;
    step(1);
    clrn = 1'b1;
    chk("base_clean", pb_clean, 5'h00);

    // latency on bit 0 press
    int_en = 5'h01;
    pb_raw = 5'h01;
    for (int e = 1; e <= 5; e++) begin
      step(1);
      chk("lat_irq_early", {4'b0, irq}, 5'h00);
      chk("lat_clean_early", pb_clean, 5'h00);
    end
    step(1);
    chk("lat_clean_e6", pb_clean, 5'h01);
    chk("lat_pending_e6", pending, 5'h01);
    chk("lat_irq_e6", {4'b0, irq}, 5'h01);

    // 3-cycle glitch on bit 1 is rejected
    int_en = 5'h03;
    pb_raw = 5'h03;
    step(3);
    pb_raw = 5'h01;
    step(10);
    chk("glitch_clean", pb_clean, 5'h01);
    chk("glitch_pending", pending, 5'h01);

    // 4-cycle pulse on bit 1 flips and then returns
    pb_raw = 5'h03;
    step(4);
    pb_raw = 5'h01;
    step(1);
    chk("pulse_clean_e5", pb_clean, 5'h01);
    step(1);
    chk("pulse_clean_e6", pb_clean, 5'h03);
    chk("pulse_pending", pending, 5'h03);
    step(8);
    chk("pulse_return", pb_clean, 5'h01);
    chk("pulse_pend_hold", pending, 5'h03);
    clr_valid = 1'b1;
    clr_mask  = 5'h03;
    step(1);
    clr_valid = 1'b0;
    chk("clr01_pending", pending, 5'h00);
    chk("clr01_irq", {4'b0, irq}, 5'h00);

    // release edge on bit 2
    int_en   = 5'h07;
    edge_sel = 5'h04;
    pb_raw   = 5'h05;
    step(6);
    chk("rel2_press_clean", pb_clean, 5'h05);
    chk("rel2_press_pend", pending, 5'h00);
    pb_raw = 5'h01;
    step(5);
    chk("rel2_pend_e5", pending, 5'h00);
    step(1);
    chk("rel2_clean", pb_clean, 5'h01);
    chk("rel2_pend", pending, 5'h04);
    chk("rel2_irq", {4'b0, irq}, 5'h01);
    clr_valid = 1'b1;
    clr_mask  = 5'h04;
    step(1);
    clr_valid = 1'b0;
    chk("clr2_pending", pending, 5'h00);

    // clear vs set on bit 3
    int_en = 5'h0F;
    pb_raw = 5'h09;
    step(6);
    chk("b3_pend", pending, 5'h08);
    clr_valid = 1'b1;
    clr_mask  = 5'h08;
    step(1);
    clr_valid = 1'b0;
    chk("b3_clr_pend", pending, 5'h00);
    chk("b3_clr_irq", {4'b0, irq}, 5'h00);
    edge_sel = 5'h0C;
    pb_raw   = 5'h01;
    step(5);
    clr_valid = 1'b1;
    clr_mask  = 5'h08;
    step(1);
    clr_valid = 1'b0;
    chk("b3_setwins_clean", pb_clean, 5'h01);
    chk("b3_setwins_pend", pending, 5'h08);
    chk("b3_setwins_irq", {4'b0, irq}, 5'h01);
    clr_valid = 1'b1;
    step(1);
    clr_valid = 1'b0;
    chk("b3_final_clr", pending, 5'h00);

    // int_en masking on bit 4
    int_en = 5'h1F;
    pb_raw = 5'h11;
    step(6);
    chk("b4_pend", pending, 5'h10);
    chk("b4_irq", {4'b0, irq}, 5'h01);
    int_en = 5'h0F;
    step(1);
    chk("b4_mask_irq", {4'b0, irq}, 5'h00);
    chk("b4_mask_pend", pending, 5'h10);
    int_en = 5'h1F;
    step(1);
    chk("b4_unmask_irq", {4'b0, irq}, 5'h01);

    // reset in the middle of a bit 1 debounce
    pb_raw = 5'h13;
    step(3);
    clrn = 1'b0;
    step(1);
    clrn = 1'b1;
    chk("mid_rst_clean", pb_clean, 5'h00);
    chk("mid_rst_pend", pending, 5'h00);
    chk("mid_rst_irq", {4'b0, irq}, 5'h00);
    step(5);
    chk("mid_clean_e5", pb_clean, 5'h00);
    step(1);
    chk("mid_clean_e6", pb_clean, 5'h13);
    chk("mid_pend_e6", pending, 5'h13);
    chk("mid_irq_e6", {4'b0, irq}, 5'h01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
